// File: rtl/dsp_seq_pkg.sv
// Shared types and default widths for the dot-product sequencer and its MAC core.
package dsp_seq_pkg;

    localparam int A_W_DEF   = 20;
    localparam int B_W_DEF   = 18;
    localparam int P_W_DEF   = 38;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dsp_mac_core.sv
// Falling-edge registered signed multiply-accumulate; acc_nxt exposes the value
// the register will take so the sequencer can capture a result on the same edge.
module dsp_mac_core
    import dsp_seq_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int P_W = P_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  sub,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic        [P_W-1:0] acc,
    output logic        [P_W-1:0] acc_nxt
);

    localparam int M_W = A_W + B_W;

    logic signed [M_W-1:0] prod;
    logic        [P_W-1:0] prod_ext;

    // Operands widened before multiplying so the product keeps full precision.
    assign prod     = M_W'(a) * M_W'(b);
    assign prod_ext = P_W'(prod);

    always_comb begin
        acc_nxt = acc;
        if (clear) begin
            acc_nxt = '0;
        end else if (en) begin
            acc_nxt = sub ? (acc - prod_ext) : (acc + prod_ext);
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/dsp_dot_product_sequencer.sv
// Job sequencer for the signed MAC: latches length/mode, streams N operand pairs
// into the MAC and returns +/- sum(A*B). All state changes on the falling edge.
module dsp_dot_product_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int P_W   = P_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  cfg_sub,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [P_W-1:0]        p_o,
    output state_t                state_dbg
);

    // Handshakes: a transfer happens on the falling edge where valid and ready are
    // both high; in_ready depends only on state, never on in_valid.
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, count_q;
    logic              sub_q;
    logic [P_W-1:0]    p_q;
    logic [P_W-1:0]    acc, acc_nxt;
    logic              fire, last_pair;
    logic              mac_clear, load_cfg, capture_p, zero_p;

    assign fire      = (state_q == ACCUM) && in_valid;
    assign last_pair = ((count_q + LEN_W'(1)) == len_q);

    always_comb begin
        state_d   = state_q;
        mac_clear = 1'b0;
        load_cfg  = 1'b0;
        capture_p = 1'b0;
        zero_p    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mac_clear = 1'b1;
                    if (cfg_len != '0) begin
                        load_cfg = 1'b1;
                        state_d  = ACCUM;
                    end else begin
                        zero_p  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (fire && last_pair) begin
                    capture_p = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            sub_q   <= 1'b0;
            count_q <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load_cfg) begin
                len_q   <= cfg_len;
                sub_q   <= cfg_sub;
                count_q <= '0;
            end else if (fire) begin
                count_q <= count_q + LEN_W'(1);
            end
            // Result is taken from the MAC's next value so it is valid on the last-pair edge.
            if (capture_p) begin
                p_q <= acc_nxt;
            end else if (zero_p) begin
                p_q <= '0;
            end
        end
    end

    dsp_mac_core #(
        .A_W(A_W),
        .B_W(B_W),
        .P_W(P_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clear),
        .en     (fire),
        .sub    (sub_q),
        .a      (a_i),
        .b      (b_i),
        .acc    (acc),
        .acc_nxt(acc_nxt)
    );

    assign busy      = (state_q == ACCUM) || (state_q == DONE);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign p_o       = p_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dsp_dot_product_sequencer.sv
// Self-checking bench: table of directed jobs, reset abort, then random jobs vs a sum model.
module tb_dsp_dot_product_sequencer;
    import dsp_seq_pkg::*;

    localparam int A_W   = 20;
    localparam int B_W   = 18;
    localparam int P_W   = 38;
    localparam int LEN_W = 8;
    localparam int MAXP  = 16;

    logic              clk = 1'b0;
    logic              reset, start, cfg_sub, in_valid, out_ready;
    logic [LEN_W-1:0]  cfg_len;
    logic [A_W-1:0]    a_i;
    logic [B_W-1:0]    b_i;
    logic              busy, in_ready, out_valid;
    logic [P_W-1:0]    p_o;
    state_t            state_dbg;

    dsp_dot_product_sequencer #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_sub(cfg_sub),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
        .out_valid(out_valid), .out_ready(out_ready), .p_o(p_o), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     len;
        bit     sub;
        int     a[MAXP];
        int     b[MAXP];
        longint exp;     // hand-computed signed result (wrapped to P_W)
        int     stall;   // 0 none, 1 toggle, 2 random
        int     hold;    // cycles out_ready held low
        bit     spur;    // pulse start mid-job
    } job_t;

    int              checks = 0;
    int              errors = 0;
    logic [P_W-1:0]  exp_q[$];
    job_t            tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    // Reference: plain signed sum of products, reduced modulo 2**P_W.
    function automatic logic [P_W-1:0] model(input job_t j);
        longint s = 0;
        for (int i = 0; i < j.len; i++) begin
            if (j.sub) s -= longint'(j.a[i]) * longint'(j.b[i]);
            else       s += longint'(j.a[i]) * longint'(j.b[i]);
        end
        return s[P_W-1:0];
    endfunction

    task automatic run_job(input job_t j, input string tag);
        logic [P_W-1:0] e;
        int  i, budget;
        logic vld, rdy;
        int  aa, bb;
        exp_q.push_back(model(j));
        rise();
        start = 1'b1; cfg_len = LEN_W'(j.len); cfg_sub = j.sub;
        fall();
        if (j.len != 0) check({tag, " in_ready_after_start"}, 64'(in_ready), 64'd1);
        i = 0; budget = 0;
        while (i < j.len && budget < 400) begin
            rise();
            start = 1'b0;
            case (j.stall)
                1:       vld = (budget % 2) == 0;
                2:       vld = ($urandom_range(0, 3) != 0);
                default: vld = 1'b1;
            endcase
            if (j.spur && i == 1) begin
                start = 1'b1; cfg_len = 8'd9; cfg_sub = ~j.sub;
            end
            aa = j.a[i]; bb = j.b[i];
            in_valid = vld; a_i = aa[A_W-1:0]; b_i = bb[B_W-1:0];
            rdy = in_ready;
            fall();
            if (vld && rdy) i++;
            else if (!vld) check({tag, " stall_no_result"}, 64'(out_valid), 64'd0);
            budget++;
        end
        if (i < j.len) check({tag, " accept_timeout"}, 64'(i), 64'(j.len));
        e = exp_q.pop_front();
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " in_ready_low"}, 64'(in_ready), 64'd0);
        check({tag, " p_o"}, 64'(p_o), 64'(e));
        for (int k = 0; k < j.hold; k++) begin
            rise();
            start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            fall();
            check({tag, " p_o_held"}, 64'(p_o), 64'(e));
            check({tag, " out_valid_held"}, 64'(out_valid), 64'd1);
        end
        rise();
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fall();
        check({tag, " idle_after_ready"}, 64'(state_dbg), 64'(IDLE));
        check({tag, " busy_low"}, 64'(busy), 64'd0);
        rise();
        out_ready = 1'b0;
        if (j.spur) begin
            fall();
            check({tag, " no_queued_start"}, 64'(state_dbg), 64'(IDLE));
        end
    endtask

    function automatic job_t mk(input int len, input bit sub, input longint exp,
                                input int stall, input int hold, input bit spur);
        job_t j;
        j.len = len; j.sub = sub; j.exp = exp; j.stall = stall; j.hold = hold; j.spur = spur;
        for (int i = 0; i < MAXP; i++) begin j.a[i] = 0; j.b[i] = 0; end
        return j;
    endfunction

    initial begin
        job_t rj;
        logic [P_W-1:0] tv;
        reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;

        tbl[0] = mk(1, 1'b0, 10, 0, 3, 1'b0);
        tbl[0].a[0] = 5; tbl[0].b[0] = 2;
        tbl[1] = mk(3, 1'b1, 9, 0, 0, 1'b0);
        tbl[1].a[0] = 5; tbl[1].b[0] = 2; tbl[1].a[1] = -3; tbl[1].b[1] = 4;
        tbl[1].a[2] = 7; tbl[1].b[2] = -1;
        tbl[2] = mk(4, 1'b0, -4000000, 1, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin tbl[2].a[i] = 1000; tbl[2].b[i] = -1000; end
        tbl[3] = mk(0, 1'b0, 0, 0, 1, 1'b0);
        tbl[4] = mk(4, 1'b0, 0, 0, 0, 1'b0);   // 4 * 2**36 wraps to 0
        for (int i = 0; i < 4; i++) begin tbl[4].a[i] = -524288; tbl[4].b[i] = -131072; end
        tbl[5] = mk(2, 1'b0, 24, 1, 0, 1'b1);
        tbl[5].a[0] = 3; tbl[5].b[0] = 4; tbl[5].a[1] = 2; tbl[5].b[1] = 6;

        rise(); rise();
        fall();
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_p_o", 64'(p_o), 64'd0);
        rise();
        reset = 1'b0;

        for (int t = 0; t < 6; t++) begin
            tv = tbl[t].exp[P_W-1:0];
            check($sformatf("vec%0d_model", t), 64'(model(tbl[t])), 64'(tv));
            run_job(tbl[t], $sformatf("vec%0d", t));
        end

        // Reset during ACCUM aborts the job and clears the held result.
        rise();
        start = 1'b1; cfg_len = 8'd4; cfg_sub = 1'b0;
        fall();
        rise();
        start = 1'b0; in_valid = 1'b1; a_i = 20'd3; b_i = 18'd3;
        fall();
        rise();
        in_valid = 1'b0; reset = 1'b1;
        fall();
        rise();
        fall();
        check("midjob_reset_state", 64'(state_dbg), 64'(IDLE));
        check("midjob_reset_busy", 64'(busy), 64'd0);
        check("midjob_reset_in_ready", 64'(in_ready), 64'd0);
        check("midjob_reset_out_valid", 64'(out_valid), 64'd0);
        check("midjob_reset_p_o", 64'(p_o), 64'd0);
        rise();
        reset = 1'b0;

        for (int n = 0; n < 32; n++) begin
            logic signed [A_W-1:0] ra;
            logic signed [B_W-1:0] rb;
            rj = mk($urandom_range(1, MAXP), 1'($urandom_range(0, 1)), 0, 2,
                    $urandom_range(0, 3), 1'b0);
            for (int i = 0; i < MAXP; i++) begin
                ra = A_W'($urandom); rb = B_W'($urandom);
                rj.a[i] = int'(ra); rj.b[i] = int'(rb);
            end
            run_job(rj, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
